// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencers.
package fc_pkg;

    localparam int FC_N_IN   = 512;
    localparam int FC_N_OUT  = 256;
    localparam int FC_LANES  = 16;
    localparam int FC_RD_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fc_state_t;

    function automatic int chunks_per_neuron(input int n_in, input int lanes);
        return n_in / lanes;
    endfunction

endpackage

// File: rtl/fc_align_pipe.sv
// Valid/tag shift register that lines issue-time control up with memory read data.
module fc_align_pipe #(
    parameter int DEPTH = 2,
    parameter int TW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    output logic [TW-1:0] out_tag,
    output logic          any_valid
);

    logic [DEPTH-1:0] vld;
    logic [TW-1:0]    tag [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];
    assign any_valid = |vld;

endmodule

// File: rtl/fc_layer_sequencer.sv
// Address and accumulate-control sequencer for one fully-connected layer.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int N_IN   = FC_N_IN,
    parameter int N_OUT  = FC_N_OUT,
    parameter int LANES  = FC_LANES,
    parameter int RD_LAT = FC_RD_LAT,
    parameter int AW_IN  = $clog2(N_IN),
    parameter int AW_OUT = $clog2(N_OUT),
    parameter int AW_W   = AW_IN + AW_OUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [AW_IN-1:0]  act_addr,
    output logic [AW_W-1:0]   w_addr,
    output logic [AW_OUT-1:0] bias_addr,
    output logic              acc_en,
    output logic              acc_first,
    output logic              acc_last,
    output logic              res_wr,
    output logic [AW_OUT-1:0] res_addr
);

    localparam int CPN = chunks_per_neuron(N_IN, LANES);
    localparam int CW  = (CPN > 1) ? $clog2(CPN) : 1;
    localparam int TW  = AW_OUT + 2;

    localparam logic [CW-1:0]     C_LAST = CW'(CPN - 1);
    localparam logic [AW_OUT-1:0] N_LAST = AW_OUT'(N_OUT - 1);

    fc_state_t state, state_next;

    logic [CW-1:0]     c;
    logic [AW_OUT-1:0] n;
    logic              issue;
    logic              c_wrap;
    logic              final_issue;

    logic              pipe_valid;
    logic              pipe_any;
    logic [TW-1:0]     pipe_tag;

    assign issue       = (state == ST_RUN) && !hold;
    assign c_wrap      = (c == C_LAST);
    assign final_issue = issue && c_wrap && (n == N_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (final_issue) state_next = ST_DRAIN;
            ST_DRAIN: if (!pipe_any) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
        endcase
    end

    // Counters end back at zero, so a following layer starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c <= '0;
            n <= '0;
        end else if (issue) begin
            if (c_wrap) begin
                c <= '0;
                n <= (n == N_LAST) ? '0 : n + 1'b1;
            end else begin
                c <= c + 1'b1;
            end
        end
    end

    assign act_addr  = AW_IN'(c) * AW_IN'(LANES);
    assign w_addr    = AW_W'(n) * AW_W'(N_IN) + AW_W'(c) * AW_W'(LANES);
    assign bias_addr = n;

    fc_align_pipe #(
        .DEPTH (RD_LAT),
        .TW    (TW)
    ) u_align (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_tag    ({c == '0, c_wrap, n}),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .any_valid (pipe_any)
    );

    assign acc_en    = pipe_valid;
    assign acc_first = pipe_valid & pipe_tag[TW-1];
    assign acc_last  = pipe_valid & pipe_tag[TW-2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_wr   <= 1'b0;
            res_addr <= '0;
        end else begin
            res_wr <= acc_last;
            if (acc_last) res_addr <= pipe_tag[AW_OUT-1:0];
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: doc/fc_layer_sequencer.md
Name: fc_layer_sequencer

Overview:
- Sequencer for one fully-connected layer on the shared 16-lane MAC datapath (ALU, bias ROM, weight ROMs, activation RAMs).
- On a start pulse, walks every output neuron and every LANES-wide input chunk. Issues activation-RAM, weight-ROM and bias-ROM addresses.
- Emits accumulator and result-write controls, delayed to line up with the fixed memory read latency.
- Sits between the top-level network controller, which chains layers with start/done, and the datapath.

Parameters:
- N_IN, 512, inputs per neuron; must be a multiple of LANES.
- N_OUT, 256, output neurons.
- LANES, 16, MAC lanes (elements consumed per issue cycle).
- RD_LAT, 2, cycles from address issue to data at the ALU inputs; must be at least 1.
- AW_IN, 9, activation address width (clog2 N_IN).
- AW_OUT, 8, neuron/bias address width (clog2 N_OUT).
- AW_W, 17, weight address width (AW_IN+AW_OUT).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run the layer; ignored unless idle.
- hold  in  1  issue stall (downstream not ready); inserts bubbles.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the layer is complete.
- act_addr  out  AW_IN  activation RAM read address, shared by all lanes.
- w_addr  out  AW_W  weight ROM read address.
- bias_addr  out  AW_OUT  bias ROM read address (current neuron).
- acc_en  out  1  data at ALU valid this cycle; accumulate.
- acc_first  out  1  with acc_en: first chunk; load bias instead of the running sum.
- acc_last  out  1  with acc_en: final chunk of the neuron.
- res_wr  out  1  write the truncated result.
- res_addr  out  AW_OUT  neuron index for res_wr.

Behaviour:
- Reset (asynchronous, active-high; clock clk): state IDLE; all counters 0; all outputs 0.
- FSM states and transitions:
  - IDLE: start=1 goes to RUN next cycle.
  - RUN: issue loop; on the final issue, go to DRAIN.
  - DRAIN: wait until the delay line and write stage are empty, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE. start is ignored while busy=1.
- Issue counters: chunk c in 0..N_IN/LANES-1 (inner), neuron n in 0..N_OUT-1 (outer).
- Issue cycle: any RUN cycle with hold=0.
  - act_addr = c*LANES.
  - w_addr = n*N_IN + c*LANES, unsigned, no overflow by construction.
  - bias_addr = n.
  - c increments. On c wrap, c returns to 0 and n increments. Final issue: n=N_OUT-1 and c=last.
- RUN with hold=1: addresses hold their values, counters freeze, and a bubble (valid=0) enters the delay line.
- hold is ignored in DRAIN/DONE; it never blocks drain.
- Delay line: RD_LAT stages carrying {valid, first=(c==0), last=(c==last), n}.
  - acc_en/acc_first/acc_last come from the last stage, so they appear exactly RD_LAT cycles after the issue cycle.
- Write stage: res_wr = acc_en&acc_last, registered one cycle later; res_addr = that entry's n.
- done asserts exactly RD_LAT+2 cycles after the final issue cycle when no further hold occurs. hold during DRAIN has no effect.
- A new start is accepted in the cycle after done (IDLE); back-to-back layers are legal.
- Reset mid-run: all pipeline valids clear immediately and no res_wr is emitted after reset. A later start restarts from n=0, c=0.
- N_IN==LANES: every issue has first=last=1.

Decomposition:
- Shared package fc_pkg: default N_IN/N_OUT/LANES/RD_LAT, the state encoding enum, and a chunks_per_neuron constant function.
- One sub-module fc_align_pipe: a parameterised RD_LAT-deep valid/tag shift register with async reset, reused by other layer sequencers.

Test Plan:
All cases use N_IN=64, N_OUT=4, LANES=16, RD_LAT=2 unless noted. Cycle 0 is the start cycle.
- Nominal run, start at cycle 0, hold=0 -> issues in cycles 1..16. act_addr sequence 0,16,32,48 repeated per neuron. Exactly 4 res_wr with res_addr 0,1,2,3, the last in cycle 19. done in cycle 20. busy=1 in cycles 1..20.
- Address check -> on the issue for n=3, c=2: w_addr=224, act_addr=32, bias_addr=3. acc_first=1 exactly 4 times; acc_last=1 exactly 4 times.
- hold=1 in cycles 5..7 -> addresses frozen in those cycles; acc_en=0 in cycles 7..9; 4 res_wr total; done in cycle 23.
- start pulsed again in cycle 8 -> ignored; only one done and 4 writes. start in the cycle after done -> second full run begins.
- reset asserted in cycle 10 for 1 cycle -> all outputs 0 immediately; no res_wr afterwards. The next start reproduces the nominal sequence.
- N_IN=16, N_OUT=2 -> acc_first=acc_last=1 on both valid cycles; res_addr 0,1; done 4 cycles after the final issue.
